sigmoid_arbiter: RTL

SIGMOID_ARBITER -- requirements
Module: sigmoid_arbiter

---
 rtl/sigmoid_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sigmoid_arbiter.sv
// Two-neuron round-robin arbiter in front of a shared combinational sigmoid unit.
// One operation takes IDLE (accept), EVAL (capture result) and HOLD (present until consumed).
module sigmoid_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    input  logic [DATA_WIDTH-1:0] req_data0,
    input  logic [DATA_WIDTH-1:0] req_data1,
    output logic [1:0]            req_ready,
    output logic [DATA_WIDTH-1:0] sig_inp,
    input  logic [DATA_WIDTH-1:0] sig_out,
    output logic [1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic [1:0]            rsp_ready,
    output logic                  busy,
    output logic [15:0]           op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_operand;
    logic                  r_owner;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [1:0]            r_rsp_valid;
    logic [15:0]           r_op_count;
    logic                  w_grant;
    logic                  w_accept;
    logic                  w_handshake;

    // Round-robin pick: on contention the requester not served last wins
    always_comb begin
        w_grant = 1'b0;
        if (req_valid == 2'b11) begin
            w_grant = ~r_last;
        end else begin
            w_grant = req_valid[1];
        end
    end

    assign w_accept    = (r_state == IDLE) && (req_valid != 2'b00);
    assign w_handshake = (r_state == HOLD) && rsp_ready[r_owner];

    // Next-state and request-side handshake; req_ready only ever rises in IDLE
    always_comb begin
        w_next_state = r_state;
        req_ready    = 2'b00;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    req_ready    = w_grant ? 2'b10 : 2'b01;
                    w_next_state = EVAL;
                end
            end
            EVAL: begin
                w_next_state = HOLD;
            end
            HOLD: begin
                if (w_handshake) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand capture, result capture, response release and bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_operand   <= '0;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_valid <= 2'b00;
            r_op_count  <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_operand <= w_grant ? req_data1 : req_data0;
                        r_owner   <= w_grant;
                    end
                end
                EVAL: begin
                    r_rsp_data  <= sig_out;
                    r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                end
                HOLD: begin
                    if (w_handshake) begin
                        r_rsp_valid <= 2'b00;
                        r_last      <= r_owner;
                        r_op_count  <= r_op_count + 16'd1;
                    end
                end
                default: begin
                    r_rsp_valid <= 2'b00;
                end
            endcase
        end
    end

    assign sig_inp   = (r_state == IDLE) ? '0 : r_operand;
    assign busy      = (r_state != IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign op_count  = r_op_count;

endmodule
